// File: rtl/gba_sound_psg_mix_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gba_sound_psg_mix_pkg
// Brief    : Shared PSG mixer types, ratio encodings and sample helpers.
// Revision : 1.0 - initial release
// ============================================================================
package gba_sound_psg_mix_pkg;

    localparam int NUM_PSG = 4;

    localparam logic [1:0] RATIO_25  = 2'd0;
    localparam logic [1:0] RATIO_50  = 2'd1;
    localparam logic [1:0] RATIO_100 = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_SCALE = 2'd2,
        ST_OUT   = 2'd3
    } psg_mix_state_t;

    // Clamping to the legal channel range keeps the 8-bit accumulator within +/-60.
    function automatic logic signed [7:0] clamp_ch(input logic signed [15:0] v);
        if (v > 16'sd15) begin
            return 8'sd15;
        end else if (v < -16'sd15) begin
            return -8'sd15;
        end else begin
            return v[7:0];
        end
    endfunction

    function automatic logic signed [15:0] shift_sat16(input logic signed [9:0] val,
                                                       input int sh);
        logic signed [47:0] w;
        w = {{38{val[9]}}, val} <<< sh;
        if (w > 48'sd32767) begin
            return 16'sd32767;
        end else if (w < -48'sd32767) begin
            return -16'sd32767;
        end else begin
            return w[15:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/gba_sound_psg_mix_if.sv
`default_nettype none
// ============================================================================
// Module   : gba_sound_psg_mix_if
// Brief    : Stereo PSG sample valid/ready link towards the final mixer.
// Revision : 1.0 - initial release
// ============================================================================
interface gba_sound_psg_mix_if;

    logic signed [15:0] out_left;
    logic signed [15:0] out_right;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output out_left,
        output out_right,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_left,
        input  out_right,
        input  out_valid,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/gba_sound_psg_mix_side.sv
`default_nettype none
// ============================================================================
// Module   : gba_sound_psg_side
// Brief    : One stereo side: per-channel accumulate, volume gain, ratio shift.
// Revision : 1.0 - initial release
// ============================================================================
module gba_sound_psg_side
    import gba_sound_psg_mix_pkg::*;
(
    input  wire logic                     clk,
    input  wire logic                     reset_n,
    input  wire logic                     acc_clr,
    input  wire logic                     acc_en,
    input  wire logic                     scale_en,
    input  wire logic [1:0]               idx,
    input  wire logic signed [7:0]        ch_val [NUM_PSG],
    input  wire logic [NUM_PSG-1:0]       ch_on,
    input  wire logic [NUM_PSG-1:0]       side_en,
    input  wire logic [2:0]               vol,
    input  wire logic [1:0]               ratio,
    output logic signed [9:0]             scaled
);

    logic signed [7:0] r_acc;
    logic signed [9:0] r_scaled;
    logic signed [7:0] w_add;
    logic signed [9:0] w_acc_x;
    logic signed [9:0] w_gain_x;
    logic signed [9:0] w_prod;
    logic signed [9:0] w_shifted;

    always_comb begin
        w_add     = (side_en[idx] & ch_on[idx]) ? ch_val[idx] : 8'sd0;
        w_acc_x   = {{2{r_acc[7]}}, r_acc};
        w_gain_x  = $signed({7'd0, vol}) + 10'sd1;
        w_prod    = w_acc_x * w_gain_x;
        w_shifted = w_prod;
        case (ratio)
            RATIO_25: w_shifted = w_prod >>> 2;
            RATIO_50: w_shifted = w_prod >>> 1;
            default:  w_shifted = w_prod;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_acc    <= 8'sd0;
            r_scaled <= 10'sd0;
        end else begin
            if (acc_clr) begin
                r_acc <= 8'sd0;
            end else if (acc_en) begin
                r_acc <= r_acc + w_add;
            end
            if (scale_en) begin
                r_scaled <= w_shifted;
            end
        end
    end

    assign scaled = r_scaled;

endmodule
`default_nettype wire

// File: rtl/gba_sound_psg_mix.sv
`default_nettype none
// ============================================================================
// Module   : gba_sound_psg_mix
// Brief    : Samples the four PSG channels per audio period and emits L/R.
// Revision : 1.0 - initial release
// ============================================================================
module gba_sound_psg_mix
    import gba_sound_psg_mix_pkg::*;
#(
    parameter int SAMPLE_DIV = 512,
    parameter int OUT_SHIFT  = 4
)(
    input  wire logic                     clk,
    input  wire logic                     reset_n,
    input  wire logic signed [15:0]       ch_out [NUM_PSG],
    input  wire logic [NUM_PSG-1:0]       ch_on,
    input  wire logic                     psg_master_en,
    input  wire logic [NUM_PSG-1:0]       en_left,
    input  wire logic [NUM_PSG-1:0]       en_right,
    input  wire logic [2:0]               vol_left,
    input  wire logic [2:0]               vol_right,
    input  wire logic [1:0]               psg_ratio,
    gba_sound_psg_mix_if.master           out_if,
    output logic                          overrun,
    input  wire logic                     overrun_clr
);

    localparam logic [15:0] c_div_last = 16'(SAMPLE_DIV - 1);

    psg_mix_state_t      r_state;
    psg_mix_state_t      w_state_next;
    logic [15:0]         r_div_cnt;
    logic [1:0]          r_idx;
    logic signed [7:0]   r_ch [NUM_PSG];
    logic [NUM_PSG-1:0]  r_on;
    logic [NUM_PSG-1:0]  r_en_l;
    logic [NUM_PSG-1:0]  r_en_r;
    logic [2:0]          r_vol_l;
    logic [2:0]          r_vol_r;
    logic [1:0]          r_ratio;
    logic signed [15:0]  r_out_left;
    logic signed [15:0]  r_out_right;
    logic                r_out_valid;

    logic                w_tick;
    logic                w_snap;
    logic                w_acc_en;
    logic                w_scale_en;
    logic                w_load;
    logic                w_overrun_set;
    logic signed [9:0]   w_scaled_l;
    logic signed [9:0]   w_scaled_r;

    assign w_tick = (r_div_cnt == c_div_last);

    always_comb begin
        w_state_next = r_state;
        w_snap       = 1'b0;
        w_acc_en     = 1'b0;
        w_scale_en   = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_tick) begin
                    w_snap       = 1'b1;
                    w_state_next = ST_ACC;
                end
            end
            ST_ACC: begin
                w_acc_en = 1'b1;
                if (r_idx == 2'd3) begin
                    w_state_next = ST_SCALE;
                end
            end
            ST_SCALE: begin
                w_scale_en   = 1'b1;
                w_state_next = ST_OUT;
            end
            ST_OUT: begin
                w_load       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Overwriting a sample the consumer never took is the only overrun source.
    assign w_overrun_set = w_load & r_out_valid & ~out_if.out_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_div_cnt   <= 16'd0;
            r_idx       <= 2'd0;
            r_on        <= '0;
            r_en_l      <= '0;
            r_en_r      <= '0;
            r_vol_l     <= 3'd0;
            r_vol_r     <= 3'd0;
            r_ratio     <= RATIO_25;
            r_out_left  <= 16'sd0;
            r_out_right <= 16'sd0;
            r_out_valid <= 1'b0;
            overrun     <= 1'b0;
            for (int i = 0; i < NUM_PSG; i++) begin
                r_ch[i] <= 8'sd0;
            end
        end else begin
            r_state   <= w_state_next;
            r_div_cnt <= w_tick ? 16'd0 : r_div_cnt + 16'd1;

            if (w_snap) begin
                r_idx <= 2'd0;
            end else if (w_acc_en) begin
                r_idx <= r_idx + 2'd1;
            end

            if (w_snap) begin
                r_on    <= ch_on;
                r_en_l  <= en_left;
                r_en_r  <= en_right;
                r_vol_l <= vol_left;
                r_vol_r <= vol_right;
                r_ratio <= psg_ratio;
                for (int i = 0; i < NUM_PSG; i++) begin
                    r_ch[i] <= psg_master_en ? clamp_ch(ch_out[i]) : 8'sd0;
                end
            end

            if (w_load) begin
                r_out_left  <= shift_sat16(w_scaled_l, OUT_SHIFT);
                r_out_right <= shift_sat16(w_scaled_r, OUT_SHIFT);
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_if.out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_overrun_set) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    gba_sound_psg_side u_side_left (
        .clk      (clk),
        .reset_n  (reset_n),
        .acc_clr  (w_snap),
        .acc_en   (w_acc_en),
        .scale_en (w_scale_en),
        .idx      (r_idx),
        .ch_val   (r_ch),
        .ch_on    (r_on),
        .side_en  (r_en_l),
        .vol      (r_vol_l),
        .ratio    (r_ratio),
        .scaled   (w_scaled_l)
    );

    gba_sound_psg_side u_side_right (
        .clk      (clk),
        .reset_n  (reset_n),
        .acc_clr  (w_snap),
        .acc_en   (w_acc_en),
        .scale_en (w_scale_en),
        .idx      (r_idx),
        .ch_val   (r_ch),
        .ch_on    (r_on),
        .side_en  (r_en_r),
        .vol      (r_vol_r),
        .ratio    (r_ratio),
        .scaled   (w_scaled_r)
    );

    assign out_if.out_left  = r_out_left;
    assign out_if.out_right = r_out_right;
    assign out_if.out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_gba_sound_psg_mix.sv
`default_nettype none
// ============================================================================
// Module   : tb_gba_sound_psg_mix
// Brief    : Directed self-checking bench for the PSG sample mixer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gba_sound_psg_mix;

    localparam int D = 16;

    logic               clk = 1'b0;
    logic               reset_n;
    logic signed [15:0] ch_out [4];
    logic [3:0]         ch_on;
    logic               psg_master_en;
    logic [3:0]         en_left;
    logic [3:0]         en_right;
    logic [2:0]         vol_left;
    logic [2:0]         vol_right;
    logic [1:0]         psg_ratio;
    logic               overrun;
    logic               overrun_clr;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    gba_sound_psg_mix_if u_if ();

    gba_sound_psg_mix #(
        .SAMPLE_DIV (D),
        .OUT_SHIFT  (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ch_out        (ch_out),
        .ch_on         (ch_on),
        .psg_master_en (psg_master_en),
        .en_left       (en_left),
        .en_right      (en_right),
        .vol_left      (vol_left),
        .vol_right     (vol_right),
        .psg_ratio     (psg_ratio),
        .out_if        (u_if),
        .overrun       (overrun),
        .overrun_clr   (overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) wait_clk(1);
    endtask

    // After this, cyc == 0 is the first cycle with reset released.
    task automatic do_reset();
        reset_n = 1'b0;
        wait_clk(2);
        reset_n = 1'b1;
        cyc     = 0;
    endtask

    task automatic set_in(input int c0, input int c1, input int c2, input int c3,
                          input logic [3:0] on, input logic [3:0] el, input logic [3:0] er,
                          input logic [2:0] vl, input logic [2:0] vr, input logic [1:0] ra);
        ch_out[0] = 16'(c0);
        ch_out[1] = 16'(c1);
        ch_out[2] = 16'(c2);
        ch_out[3] = 16'(c3);
        ch_on     = on;
        en_left   = el;
        en_right  = er;
        vol_left  = vl;
        vol_right = vr;
        psg_ratio = ra;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (u_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", u_if.out_valid); end
        n_tests++; if (u_if.out_left !== 16'sd0) begin n_fail++; $display("FAIL reset_left: got %0d want 0", u_if.out_left); end
        n_tests++; if (u_if.out_right !== 16'sd0) begin n_fail++; $display("FAIL reset_right: got %0d want 0", u_if.out_right); end
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %0b want 0", overrun); end
    endtask

    task automatic test_single_channel();
        psg_master_en  = 1'b1;
        u_if.out_ready = 1'b1;
        set_in(15, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000, 3'd7, 3'd0, 2'd2);
        do_reset();
        wait_until(D + 5);
        n_tests++; if (u_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %0b want 0", u_if.out_valid); end
        wait_until(D + 6);
        n_tests++; if (u_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b want 1", u_if.out_valid); end
        n_tests++; if (u_if.out_left !== 16'sd1920) begin n_fail++; $display("FAIL single_left: got %0d want 1920", u_if.out_left); end
        n_tests++; if (u_if.out_right !== 16'sd0) begin n_fail++; $display("FAIL single_right: got %0d want 0", u_if.out_right); end
        wait_until(D + 7);
        n_tests++; if (u_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop: got %0b want 0", u_if.out_valid); end
    endtask

    task automatic test_gain_ratio();
        logic signed [15:0] exp_l;
        logic signed [15:0] exp_r;
        psg_master_en  = 1'b1;
        u_if.out_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            case (v)
                0: begin set_in(-15, -15, -15, -15, 4'hF, 4'hF, 4'hF, 3'd0, 3'd0, 2'd0); exp_l = -16'sd240; exp_r = -16'sd240; end
                1: begin set_in(-15, -15, -15, -15, 4'hF, 4'hF, 4'hF, 3'd0, 3'd1, 2'd0); exp_l = -16'sd240; exp_r = -16'sd480; end
                2: begin set_in(15, -7, 3, 10, 4'hF, 4'b0101, 4'b1010, 3'd2, 3'd7, 2'd1); exp_l = 16'sd432; exp_r = 16'sd192; end
                3: begin set_in(15, -7, 3, 10, 4'hF, 4'b0101, 4'b1010, 3'd2, 3'd7, 2'd3); exp_l = 16'sd864; exp_r = 16'sd384; end
                4: begin set_in(15, -7, 3, 10, 4'hF, 4'b0010, 4'b0001, 3'd0, 3'd7, 2'd1); exp_l = -16'sd64; exp_r = 16'sd960; end
                5: begin set_in(15, 15, 15, 15, 4'hF, 4'hF, 4'hF, 3'd7, 3'd7, 2'd2); exp_l = 16'sd7680; exp_r = 16'sd7680; end
                default: begin set_in(15, -7, 0, 0, 4'b0011, 4'b0001, 4'b0010, 3'd0, 3'd0, 2'd0); exp_l = 16'sd48; exp_r = -16'sd32; end
            endcase
            do_reset();
            wait_until(D + 6);
            n_tests++; if (u_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL gain_valid[%0d]: got %0b want 1", v, u_if.out_valid); end
            n_tests++; if (u_if.out_left !== exp_l) begin n_fail++; $display("FAIL gain_left[%0d]: got %0d want %0d", v, u_if.out_left, exp_l); end
            n_tests++; if (u_if.out_right !== exp_r) begin n_fail++; $display("FAIL gain_right[%0d]: got %0d want %0d", v, u_if.out_right, exp_r); end
        end
    endtask

    task automatic test_muting();
        u_if.out_ready = 1'b1;
        psg_master_en  = 1'b1;
        set_in(15, 15, 15, 15, 4'h0, 4'hF, 4'hF, 3'd7, 3'd7, 2'd2);
        do_reset();
        wait_until(D + 6);
        n_tests++; if (u_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL mute_on_valid: got %0b want 1", u_if.out_valid); end
        n_tests++; if (u_if.out_left !== 16'sd0) begin n_fail++; $display("FAIL mute_on_left: got %0d want 0", u_if.out_left); end
        n_tests++; if (u_if.out_right !== 16'sd0) begin n_fail++; $display("FAIL mute_on_right: got %0d want 0", u_if.out_right); end

        psg_master_en = 1'b0;
        ch_on         = 4'hF;
        do_reset();
        wait_until(D + 6);
        n_tests++; if (u_if.out_left !== 16'sd0) begin n_fail++; $display("FAIL mute_master_left: got %0d want 0", u_if.out_left); end
        n_tests++; if (u_if.out_right !== 16'sd0) begin n_fail++; $display("FAIL mute_master_right: got %0d want 0", u_if.out_right); end

        psg_master_en = 1'b1;
        set_in(15, 0, 0, 0, 4'b0001, 4'b0001, 4'b0001, 3'd7, 3'd7, 2'd2);
        do_reset();
        wait_until(D);
        // The snapshot edge has passed; none of these may reach this sample.
        psg_master_en = 1'b0;
        set_in(-15, 0, 0, 0, 4'h0, 4'h0, 4'h0, 3'd0, 3'd0, 2'd0);
        wait_until(D + 6);
        n_tests++; if (u_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL late_change_valid: got %0b want 1", u_if.out_valid); end
        n_tests++; if (u_if.out_left !== 16'sd1920) begin n_fail++; $display("FAIL late_change_left: got %0d want 1920", u_if.out_left); end
        n_tests++; if (u_if.out_right !== 16'sd1920) begin n_fail++; $display("FAIL late_change_right: got %0d want 1920", u_if.out_right); end
        psg_master_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        u_if.out_ready = 1'b0;
        overrun_clr    = 1'b0;
        psg_master_en  = 1'b1;
        set_in(15, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000, 3'd7, 3'd0, 2'd2);
        do_reset();
        wait_until(D + 6);
        n_tests++; if (u_if.out_left !== 16'sd1920) begin n_fail++; $display("FAIL bp_first_left: got %0d want 1920", u_if.out_left); end
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL bp_first_overrun: got %0b want 0", overrun); end
        ch_out[0] = -16'sd15;
        wait_until(2 * D + 5);
        n_tests++; if (u_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid: got %0b want 1", u_if.out_valid); end
        n_tests++; if (u_if.out_left !== 16'sd1920) begin n_fail++; $display("FAIL bp_hold_left: got %0d want 1920", u_if.out_left); end
        wait_until(2 * D + 6);
        n_tests++; if (u_if.out_left !== -16'sd1920) begin n_fail++; $display("FAIL bp_overwrite_left: got %0d want -1920", u_if.out_left); end
        n_tests++; if (u_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_overwrite_valid: got %0b want 1", u_if.out_valid); end
        n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL bp_overrun_set: got %0b want 1", overrun); end
        overrun_clr    = 1'b1;
        u_if.out_ready = 1'b1;
        wait_until(2 * D + 7);
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL bp_overrun_clr: got %0b want 0", overrun); end
        n_tests++; if (u_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_transfer_valid: got %0b want 0", u_if.out_valid); end
        overrun_clr    = 1'b0;
        u_if.out_ready = 1'b0;
        ch_out[0]      = 16'sd15;
        wait_until(3 * D + 6);
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL bp_third_overrun: got %0b want 0", overrun); end
        wait_until(4 * D + 5);
        overrun_clr = 1'b1;
        wait_until(4 * D + 6);
        n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL bp_set_beats_clr: got %0b want 1", overrun); end
        wait_until(4 * D + 7);
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL bp_clr_after: got %0b want 0", overrun); end
        overrun_clr = 1'b0;
        wait_until(5 * D + 5);
        u_if.out_ready = 1'b1;
        wait_until(5 * D + 6);
        n_tests++; if (u_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_same_cycle_valid: got %0b want 1", u_if.out_valid); end
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL bp_same_cycle_overrun: got %0b want 0", overrun); end
        wait_until(5 * D + 7);
        n_tests++; if (u_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_final_drop: got %0b want 0", u_if.out_valid); end
    endtask

    task automatic test_reset_mid();
        u_if.out_ready = 1'b0;
        psg_master_en  = 1'b1;
        set_in(15, 0, 0, 0, 4'b0001, 4'b0001, 4'b0001, 3'd7, 3'd7, 2'd2);
        do_reset();
        wait_until(D + 6);
        n_tests++; if (u_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valid: got %0b want 1", u_if.out_valid); end
        wait_until(2 * D + 1);
        reset_n = 1'b0;
        wait_clk(1);
        n_tests++; if (u_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %0b want 0", u_if.out_valid); end
        n_tests++; if (u_if.out_left !== 16'sd0) begin n_fail++; $display("FAIL rmid_left: got %0d want 0", u_if.out_left); end
        n_tests++; if (u_if.out_right !== 16'sd0) begin n_fail++; $display("FAIL rmid_right: got %0d want 0", u_if.out_right); end
        reset_n = 1'b1;
        cyc     = 0;
        wait_until(D + 5);
        n_tests++; if (u_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_no_partial: got %0b want 0", u_if.out_valid); end
        wait_until(D + 6);
        n_tests++; if (u_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_next_valid: got %0b want 1", u_if.out_valid); end
        n_tests++; if (u_if.out_left !== 16'sd1920) begin n_fail++; $display("FAIL rmid_next_left: got %0d want 1920", u_if.out_left); end
    endtask

    initial begin
        reset_n        = 1'b0;
        overrun_clr    = 1'b0;
        psg_master_en  = 1'b1;
        u_if.out_ready = 1'b1;
        set_in(0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 3'd0, 3'd0, 2'd0);

        test_reset();
        test_single_channel();
        test_gain_ratio();
        test_muting();
        test_back_to_back();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gba_sound_psg_mix.md
# gba_sound_psg_mix

Consumer end of the PSG channel outputs. Samples the four legacy channel outputs (`sound_out`/`sound_on` of ch1–ch4) at a fixed audio rate and applies SOUNDCNT_L per-side enables and master volume plus the SOUNDCNT_H PSG ratio. Emits one signed left/right PSG sample per period over a valid/ready handshake to the final FIFO/PSG mixer. Register fields arrive as decoded ports from the sound top level; this block has no bus port.

## Interface
Parameters:
- SAMPLE_DIV, 512: clk cycles per sample period (32768 Hz at 16.78 MHz); legal range 8..65535.
- OUT_SHIFT, 4: left shift applied to the final scaled sum.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  codebase reset, active-low, synchronous (decided: one clock; reset is synchronous and active-low).
- ch_out[0..3]  in  16 each  signed channel sample, -15..15.
- ch_on[0..3]  in  1 each  channel active; 0 forces a contribution of 0.
- psg_master_en  in  1  SOUNDCNT_X master enable.
- en_left, en_right  in  4 each  per-channel side enables (bit n = ch n+1).
- vol_left, vol_right  in  3 each  master volume 0..7; gain is vol+1.
- psg_ratio  in  2  0 = 25 %, 1 = 50 %, 2 = 100 %, 3 = treated as 100 %.
- out_left, out_right  out  16 each  signed sample.
- out_valid  out  1  sample available.
- out_ready  in  1  downstream accepts.
- overrun  out  1  sticky: an unaccepted sample was overwritten.
- overrun_clr  in  1  clears overrun.

## Operation
- Divider `div_cnt` counts 0..SAMPLE_DIV-1 and wraps. `tick` is asserted on the cycle `div_cnt == SAMPLE_DIV-1`.
- On tick, snapshot all inputs in the same cycle: ch_out, ch_on, enables, volumes, ratio, master_en. If master_en = 0, every snapshot channel value is 0.
- FSM states:
  - IDLE: on tick go to ACC.
  - ACC: 4 cycles, index 0..3. Per cycle, acc_l += en_left[i] & ch_on[i] ? ch[i] : 0, and likewise for acc_r. After index 3 go to SCALE.
  - SCALE: 1 cycle. Compute acc × (vol+1), then shift arithmetically right by 2 (25 %), 1 (50 %) or 0 (100 %/3). Go to OUT.
  - OUT: 1 cycle. Load the output registers with the result <<< OUT_SHIFT, set out_valid, go to IDLE.
- Widths:
  - acc: 8-bit signed, range ±60.
  - Product: 10-bit signed, range ±480.
  - Output: sign-extended to 16 bits before the shift.
  - No saturation is needed for OUT_SHIFT ≤ 6. For larger OUT_SHIFT the result saturates to ±32767.
- Handshake:
  - out_valid & out_ready in a cycle = transfer. out_valid drops the next cycle unless OUT loads a new sample in that same cycle.
  - Outputs are stable while out_valid = 1 and not ready.
  - OUT with out_valid = 1 and no transfer in that cycle: overwrite the outputs, keep valid, set overrun.
  - OUT with a transfer in the same cycle: old sample consumed, new one loaded, no overrun.
- overrun_clr in the same cycle as an overrun set: the set wins.
- A tick arriving while the FSM is not IDLE is ignored. This is impossible for SAMPLE_DIV ≥ 8.

## Timing
- Reset values (reset_n = 0 at a clk edge):
  - out_left = out_right = 0, out_valid = 0, overrun = 0.
  - div_cnt = 0, state IDLE, accumulators 0.
- Reset mid-FSM aborts the sample in progress; no partial output.
- Latency: tick in cycle T (snapshot) → ACC T+1..T+4 → SCALE T+5 → OUT T+6. out_valid is visible in cycle T+7.
- First tick after reset release falls at cycle SAMPLE_DIV-1.
- Input changes after the tick cycle do not affect the current sample.

## Structure
- Shared sound package holds:
  - psg_ratio encodings (RATIO_25 = 0, RATIO_50 = 1, RATIO_100 = 2).
  - PSG channel count NUM_PSG = 4.
  - The FSM state enum `psg_mix_state_t`.
- One sub-module, `gba_sound_psg_side`. It holds one side's accumulate/scale datapath and is instantiated twice (left, right). The FSM and divider live in the top.

## Test plan
- **Single channel, full gain:** ch0 = +15, ch_on = 0001, en_left = 0001, en_right = 0, vol_left = 7, ratio = 2, out_ready = 1 → out_left = 15×8<<4 = 1920, out_right = 0; valid visible exactly 7 cycles after tick.
- **Four channels, 25 %:** all ch = -15, all on and enabled, vol = 0, ratio = 0 → acc = -60, product = -60, >>>2 = -15, out = -240 both sides.
- **Muting:** ch_on = 0 or psg_master_en = 0 with ch = +15 → out = 0. An input change one cycle after tick has no effect on that sample.
- **Backpressure:** out_ready = 0 across two periods → first sample held stable, second overwrites it, overrun = 1; overrun_clr → 0.
- **Reset mid-operation:** reset_n low during ACC → out_valid = 0 and outputs 0 next cycle; next tick at SAMPLE_DIV-1 cycles after release.
